// File: rtl/imm_pkg.sv
// imm_pkg: immediate format encodings, major opcodes and sign-extension helper.
// Shared by imm_decode and imm_gen_pipe.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'b000,
    FMT_U    = 3'b001,
    FMT_S    = 3'b010,
    FMT_B    = 3'b011,
    FMT_J    = 3'b100,
    FMT_NONE = 3'b111
  } imm_fmt_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Replicates bit msb of value upward; callers cast to XLEN.
  function automatic logic [63:0] sext(
    input logic [31:0] value,
    input logic [4:0]  msb
  );
    logic [5:0]         sh;
    logic signed [63:0] t;
    sh = 6'd63 - {1'b0, msb};
    t  = $signed({32'b0, value} << sh);
    return t >>> sh;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational opcode decode and immediate assembly.
// IMM_GEN_PIPE_RVC_EN adds the RVC subset and the rvc flag output.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
`ifdef IMM_GEN_PIPE_RVC_EN
  ,
  output logic            rvc
`endif
);

  logic [31:0] raw;
  logic [4:0]  msb;

  always_comb begin
    fmt = FMT_NONE;
    raw = '0;
    msb = '0;
`ifdef IMM_GEN_PIPE_RVC_EN
    rvc = 1'b0;
    if (instr[1:0] != 2'b11) begin
      rvc = 1'b1;
      unique case ({instr[1:0], instr[15:13]})
        5'b01_000, 5'b01_010: begin
          fmt = FMT_I;
          raw = {26'b0, instr[12], instr[6:2]};
          msb = 5'd5;
        end
        5'b01_011: begin
          // rd=x2 is C.ADDI16SP, outside the subset
          if (instr[11:7] != 5'd2) begin
            fmt = FMT_U;
            raw = {14'b0, instr[12], instr[6:2], 12'b0};
            msb = 5'd17;
          end
        end
        5'b01_101: begin
          fmt = FMT_J;
          raw = {20'b0, instr[12], instr[8],
                 instr[10:9], instr[6], instr[7],
                 instr[2], instr[11], instr[5:3],
                 1'b0};
          msb = 5'd11;
        end
        5'b01_110, 5'b01_111: begin
          fmt = FMT_B;
          raw = {23'b0, instr[12], instr[6:5],
                 instr[2], instr[11:10],
                 instr[4:3], 1'b0};
          msb = 5'd8;
        end
        5'b00_010: begin
          fmt = FMT_I;
          raw = {25'b0, instr[5], instr[12:10],
                 instr[6], 2'b00};
          msb = 5'd7;
        end
        5'b00_110: begin
          fmt = FMT_S;
          raw = {25'b0, instr[5], instr[12:10],
                 instr[6], 2'b00};
          msb = 5'd7;
        end
        default: ;
      endcase
    end else
`endif
    begin
      unique case (instr[6:0])
        OPC_OP_IMM, OPC_LOAD,
        OPC_JALR, OPC_SYSTEM: begin
          fmt = FMT_I;
          raw = {20'b0, instr[31:20]};
          msb = 5'd11;
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt = FMT_U;
          raw = {instr[31:12], 12'b0};
          msb = 5'd31;
        end
        OPC_STORE: begin
          fmt = FMT_S;
          raw = {20'b0, instr[31:25], instr[11:7]};
          msb = 5'd11;
        end
        OPC_BRANCH: begin
          fmt = FMT_B;
          raw = {19'b0, instr[31], instr[7],
                 instr[30:25], instr[11:8], 1'b0};
          msb = 5'd12;
        end
        OPC_JAL: begin
          fmt = FMT_J;
          raw = {11'b0, instr[31], instr[19:12],
                 instr[20], instr[30:21], 1'b0};
          msb = 5'd20;
        end
        default: ;
      endcase
    end
  end

  assign imm = XLEN'(sext(raw, msb));

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a 2-entry skid buffer.
// Define IMM_GEN_PIPE_RVC_EN for RVC decode and the out_rvc port.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_PIPE_RVC_EN
  ,
  output logic             out_rvc
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
`ifdef IMM_GEN_PIPE_RVC_EN
    logic             rvc;
`endif
  } entry_t;

  imm_fmt_e        dec_fmt;
  logic [XLEN-1:0] dec_imm;
  entry_t          in_entry;
  entry_t          out_d, out_q;
  entry_t          skid_d, skid_q;
  logic            out_vld_d, out_vld_q;
  logic            skid_vld_d, skid_vld_q;
  logic            in_xfer, out_xfer, out_load;

`ifdef IMM_GEN_PIPE_RVC_EN
  logic dec_rvc;
`endif

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr (in_instr),
    .fmt   (dec_fmt),
    .imm   (dec_imm)
`ifdef IMM_GEN_PIPE_RVC_EN
    ,
    .rvc   (dec_rvc)
`endif
  );

  always_comb begin
    in_entry.imm   = dec_imm;
    in_entry.fmt   = dec_fmt;
    in_entry.instr = in_instr;
    in_entry.tag   = in_tag;
`ifdef IMM_GEN_PIPE_RVC_EN
    in_entry.rvc   = dec_rvc;
`endif
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_vld_q & out_ready;
  assign out_load = ~out_vld_q | out_ready;

  // A full skid implies a full output register and in_ready low.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (skid_vld_q) begin
      if (out_ready) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (out_load) begin
        out_d     = in_entry;
        out_vld_d = 1'b1;
      end else begin
        skid_d     = in_entry;
        skid_vld_d = 1'b1;
      end
    end else if (out_xfer) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_q      <= '0;
      out_q.fmt  <= FMT_NONE;
      skid_q     <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = ~skid_vld_q;
  assign out_valid = out_vld_q;
  assign out_imm   = out_q.imm;
  assign out_fmt   = out_q.fmt;
  assign out_instr = out_q.instr;
  assign out_tag   = out_q.tag;
`ifdef IMM_GEN_PIPE_RVC_EN
  assign out_rvc   = out_q.rvc;
`endif

endmodule
